// File: rtl/led_status_ctrl_if.sv
// Control/status bundle for the multi-channel status-LED driver.
// The board-level controller (master) supplies per-channel modes, blink
// half-periods and activity strobes; the LED driver (slave) returns the
// shared prescaler tick and the registered LED drive.
interface led_status_ctrl_if #(
   parameter int CHANNELS = 4,
   parameter int PERIOD_W = 10
);
   logic [2*CHANNELS-1:0]        mode_i;
   logic [PERIOD_W*CHANNELS-1:0] half_period_i;
   logic [CHANNELS-1:0]          act_i;
   logic                         tick_o;
   logic [CHANNELS-1:0]          led_o;

   modport master (
      output mode_i, half_period_i, act_i,
      input  tick_o, led_o
   );

   modport slave (
      input  mode_i, half_period_i, act_i,
      output tick_o, led_o
   );
endinterface

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver.
// One shared prescaler produces a registered tick every DIV clocks. Each
// channel drives its LED OFF, ON, BLINK (programmable half-period in ticks)
// or ACTIVITY (blinks while a stretched activity strobe is pending).
// Any change of a channel's mode restarts its blink engine at phase=1, so a
// freshly selected BLINK shows the LED lit on the very next cycle.
// "stretch" in the channel rules always refers to the registered value at
// the edge; the LED shows the phase as updated on that same edge.
module led_status_ctrl #(
   parameter int CHANNELS      = 4,
   parameter int CLK_HZ        = 25_000_000,
   parameter int TICK_HZ       = 1000,
   parameter int PERIOD_W      = 10,
   parameter int STRETCH_TICKS = 50
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   led_status_ctrl_if.slave   bus
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = $clog2(DIV);
   localparam int STR_W = $clog2(STRETCH_TICKS + 1);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_TICKS);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_ACT   = 2'd3
   } mode_e;

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic                tick_q, tick_d;

   logic [1:0]          mode_q [CHANNELS];
   logic [1:0]          mode_d [CHANNELS];
   logic [PERIOD_W-1:0] cnt_q  [CHANNELS];
   logic [PERIOD_W-1:0] cnt_d  [CHANNELS];
   logic [STR_W-1:0]    str_q  [CHANNELS];
   logic [STR_W-1:0]    str_d  [CHANNELS];
   logic [CHANNELS-1:0] ph_q, ph_d;
   logic [CHANNELS-1:0] led_q, led_d;

   // Prescaler: free-running 0..DIV-1, tick is the registered wrap strobe.
   always_comb begin
      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      tick_d = (pre_q == PRE_LAST);
   end

   // Per-channel mode tracking, activity stretch, blink engine and LED select.
   always_comb begin
      mode_e               mode_now;
      logic [PERIOD_W-1:0] hp;
      logic [PERIOD_W-1:0] hp_m1;
      logic                run;
      mode_now = MODE_OFF;
      hp       = '0;
      hp_m1    = '0;
      run      = 1'b0;
      ph_d     = '1;
      led_d    = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         mode_now  = mode_e'(bus.mode_i[2*k +: 2]);
         hp        = bus.half_period_i[PERIOD_W*k +: PERIOD_W];
         // A programmed half-period of 0 behaves like 1.
         hp_m1     = (hp == '0) ? '0 : hp - PERIOD_W'(1);
         run       = (mode_now == MODE_BLINK) ||
                     ((mode_now == MODE_ACT) && (str_q[k] != '0));
         mode_d[k] = bus.mode_i[2*k +: 2];

         // A new strobe wins over a same-cycle tick decrement.
         str_d[k] = str_q[k];
         if (bus.act_i[k]) begin
            str_d[k] = STR_LOAD;
         end else if (tick_q && (str_q[k] != '0)) begin
            str_d[k] = str_q[k] - STR_W'(1);
         end

         // Idle engines (and any mode change) sit at cnt=0, phase=1.
         cnt_d[k] = '0;
         ph_d[k]  = 1'b1;
         if ((mode_now == mode_e'(mode_q[k])) && run) begin
            cnt_d[k] = cnt_q[k];
            ph_d[k]  = ph_q[k];
            if (tick_q) begin
               // >= so a half-period lowered below cnt toggles immediately.
               if (cnt_q[k] >= hp_m1) begin
                  cnt_d[k] = '0;
                  ph_d[k]  = ~ph_q[k];
               end else begin
                  cnt_d[k] = cnt_q[k] + PERIOD_W'(1);
               end
            end
         end

         case (mode_now)
            MODE_OFF:   led_d[k] = 1'b0;
            MODE_ON:    led_d[k] = 1'b1;
            MODE_BLINK: led_d[k] = ph_d[k];
            default:    led_d[k] = (str_q[k] == '0) ? 1'b1 : ph_d[k];
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         ph_q   <= '1;
         led_q  <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            mode_q[k] <= 2'd0;
            cnt_q[k]  <= '0;
            str_q[k]  <= '0;
         end
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
         ph_q   <= ph_d;
         led_q  <= led_d;
         for (int k = 0; k < CHANNELS; k++) begin
            mode_q[k] <= mode_d[k];
            cnt_q[k]  <= cnt_d[k];
            str_q[k]  <= str_d[k];
         end
      end
   end

   assign bus.tick_o = tick_q;
   assign bus.led_o  = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with DIV=10, STRETCH_TICKS=3, 4 channels.
// n counts rising edges since reset release; with DIV=10 tick_o is high
// after edges 10,20,... and the channels act on ticks at edges 11,21,...
module tb_led_status_ctrl;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   int n           = 0;
   int vectors     = 0;
   int miscompares = 0;

   logic e0, e1, e2, e3;

   led_status_ctrl_if #(.CHANNELS(4), .PERIOD_W(10)) bus ();

   led_status_ctrl #(
      .CHANNELS      (4),
      .CLK_HZ        (1000),
      .TICK_HZ       (100),
      .PERIOD_W      (10),
      .STRETCH_TICKS (3)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   // One rising edge, then return at the falling edge for sampling/driving.
   task automatic cyc();
      @(posedge clk_i);
      if (rst_ni) n = n + 1;
      else        n = 0;
      @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [3:0] exp_led);
      logic exp_tick;
      exp_tick = (n != 0) && (n % 10 == 0);
      vectors++;
      assert (bus.led_o === exp_led) else begin
         miscompares++;
         $error("FAIL %s led n=%0d: got %b expected %b", tag, n, bus.led_o, exp_led);
      end
      vectors++;
      assert (bus.tick_o === exp_tick) else begin
         miscompares++;
         $error("FAIL %s tick n=%0d: got %b expected %b", tag, n, bus.tick_o, exp_tick);
      end
   endtask

   initial begin
      bus.mode_i        = 8'h55;
      bus.half_period_i = '0;
      bus.act_i         = '0;
      @(negedge clk_i);

      // 1. reset with all channels ON, then release
      repeat (5) begin
         cyc();
         chk("reset", 4'h0);
      end
      rst_ni = 1'b1;
      cyc();
      chk("release", 4'hF);
      while (n < 32) begin
         cyc();
         chk("presc", 4'hF);
      end

      // 2. ch0 BLINK, half_period=2, then 0
      bus.mode_i[1:0]       = 2'd2;
      bus.half_period_i[9:0] = 10'd2;
      while (n < 251) begin
         cyc();
         e0 = (n < 51) ? 1'b1 : ((((n - 51) / 20) % 2 == 0) ? 1'b0 : 1'b1);
         chk("blink_hp2", {3'b111, e0});
      end
      bus.half_period_i[9:0] = 10'd0;
      while (n < 301) begin
         cyc();
         e0 = ((((n - 251) / 10) % 2) == 0) ? 1'b0 : 1'b1;
         chk("blink_hp0", {3'b111, e0});
      end

      // 3. ch0 OFF; ch1 ACTIVITY hp=1, pulse then reload mid-stretch
      bus.mode_i[1:0]          = 2'd0;
      bus.mode_i[3:2]          = 2'd3;
      bus.half_period_i[19:10] = 10'd1;
      while (n < 360) begin
         cyc();
         e1 = ((n >= 311 && n <= 320) || (n >= 331 && n <= 340) || n == 351) ? 1'b0 : 1'b1;
         chk("act_reload", {2'b11, e1, 1'b0});
         if (n == 305 || n == 324) bus.act_i[1] = 1'b1;
         if (n == 306 || n == 325) bus.act_i[1] = 1'b0;
      end

      // 4. pulse coincident with tick while stretch=1
      while (n < 430) begin
         cyc();
         e1 = ((n >= 371 && n <= 380) || (n >= 391 && n <= 400) ||
               (n >= 411 && n <= 420)) ? 1'b0 : 1'b1;
         chk("act_tick", {2'b11, e1, 1'b0});
         if (n == 364 || n == 390) bus.act_i[1] = 1'b1;
         if (n == 365 || n == 391) bus.act_i[1] = 1'b0;
      end

      // 5. ch2 BLINK->ACTIVITY->BLINK, changes landing on tick edges
      while (n < 432) begin
         cyc();
         chk("pre_mc", 4'b1110);
      end
      bus.mode_i[5:4]          = 2'd2;
      bus.half_period_i[29:20] = 10'd1;
      while (n < 480) begin
         cyc();
         e2 = ((n >= 441 && n <= 450) || (n >= 471)) ? 1'b0 : 1'b1;
         chk("mode_on_tick", {1'b1, e2, 2'b10});
         if (n == 450) bus.mode_i[5:4] = 2'd3;
         if (n == 460) bus.mode_i[5:4] = 2'd2;
      end

      // 6. ch3 BLINK hp=1 with act, reset when phase=0 and stretch=2
      bus.mode_i[7:6]          = 2'd2;
      bus.half_period_i[39:30] = 10'd1;
      bus.act_i[3]             = 1'b1;
      while (n < 495) begin
         cyc();
         if (n == 481) bus.act_i[3] = 1'b0;
         e2 = (n >= 481 && n <= 490) ? 1'b1 : 1'b0;
         e3 = (n >= 491) ? 1'b0 : 1'b1;
         chk("ch3_run", {e3, e2, 2'b10});
      end
      rst_ni = 1'b0;
      repeat (2) begin
         cyc();
         chk("mid_reset", 4'h0);
      end
      rst_ni = 1'b1;
      while (n < 12) begin
         cyc();
         chk("post_reset", (n < 11) ? 4'hE : 4'h2);
      end
      bus.mode_i[7:6] = 2'd3;
      while (n < 40) begin
         cyc();
         e2 = (n >= 21 && n <= 30) ? 1'b1 : 1'b0;
         chk("stretch_cleared", {1'b1, e2, 2'b10});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
